pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage pipelined RISC-V core.
- Detects load-use hazards and generates PC/IF-ID write enables and the ID/EX control bubble.
- Flushes IF/ID, ID/EX and EX/MEM when a branch resolves taken in MEM (Branch & Zero at EX/MEM).
- Adds a debug halt/single-step FSM and saturating stall/flush performance counters; sits beside the forwarding unit and drives the pipeline register enables.

Parameters:
REG_ADDR_W, 5, register index width
CNT_W, 16, width of stall/flush performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
memread_idex  in  1  MemRead of the instruction in ID/EX
rd_idex  in  REG_ADDR_W  destination register in ID/EX
rs1_ifid  in  REG_ADDR_W  rs1 of the instruction in IF/ID
rs2_ifid  in  REG_ADDR_W  rs2 of the instruction in IF/ID
rs1_used  in  1  IF/ID instruction reads rs1
rs2_used  in  1  IF/ID instruction reads rs2
branch_taken_exmem  in  1  Branch_exmem & Zero_exmem
dbg_halt  in  1  level: request/hold halt
dbg_step  in  1  pulse: execute one instruction while halted
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ctrl_bubble  out  1  zero control signals into ID/EX
flush_ifid  out  1  clear IF/ID
flush_idex  out  1  clear ID/EX
flush_exmem  out  1  clear EX/MEM control
halted  out  1  FSM in HALTED
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  branch flush events

Behaviour:
- Hazard outputs (pc_write, ifid_write, ctrl_bubble, flush_*) are combinational from inputs and the current state. The state, halted and the counters are registered.
- load_use = memread_idex & (rd_idex != 0) & ((rs1_used & rd_idex==rs1_ifid) | (rs2_used & rd_idex==rs2_ifid)).
- Priority, highest first: branch flush > load-use stall > halt gating.
- Branch flush (any state): flush_ifid = flush_idex = flush_exmem = 1, pc_write = 1 (PC takes the redirect target), ifid_write = 1, ctrl_bubble = 1.
  - load_use is ignored in the same cycle.
  - flush_cnt increments.
- Load-use (no flush, state RUN or STEP): pc_write = 0, ifid_write = 0, ctrl_bubble = 1, flush_* = 0.
  - stall_cnt increments.
  - Exactly one bubble per dependent load: the following cycle the load has left ID/EX, so load_use clears naturally.
- Default in RUN: pc_write = ifid_write = 1, ctrl_bubble = 0, flush_* = 0.
- FSM states:
  - RUN: dbg_halt=1 -> HALTED next cycle; the current cycle still behaves as RUN.
  - HALTED: pc_write = ifid_write = 0, ctrl_bubble = 1 (pipeline drains), halted = 1.
    - dbg_halt=0 -> RUN.
    - else dbg_step=1 -> STEP.
    - dbg_step while dbg_halt=0: RUN wins.
  - STEP: behaves as RUN for one cycle, then returns to HALTED unconditionally.
    - If that cycle is a load-use stall, STEP is held: stay in STEP until one non-stalled advance occurs.
- A branch flush in HALTED or STEP overrides gating: pc_write = 1 so the target is not lost. The FSM state is unaffected.
- Counters saturate at all-ones and do not wrap. A stall cycle in HALTED gating is not counted; only load-use cycles count.
- Reset (reset=0 at clk edge): state = RUN, halted = 0, stall_cnt = 0, flush_cnt = 0.
  - Hazard outputs forced to reset-safe values while reset=0: pc_write = 0, ifid_write = 0, ctrl_bubble = 1, flush_* = 1.
  - Reset mid-halt or mid-step returns to RUN.
- Latency: hazard responses take 0 cycles (same cycle). FSM transitions take 1 cycle.

Test Plan:
- Reset: hold reset=0 for 2 cycles with branch_taken_exmem=1 -> flush_*=1, pc_write=0, counters 0, halted=0; release -> pc_write=1, ifid_write=1.
- Load-use: memread_idex=1, rd_idex=5, rs1_ifid=5, rs1_used=1 for 1 cycle -> pc_write=0, ifid_write=0, ctrl_bubble=1, stall_cnt=1. Repeat with rd_idex=0 -> no stall.
- Simultaneous branch and load-use: both asserted -> flush_ifid/idex/exmem=1, pc_write=1; stall_cnt unchanged, flush_cnt +1.
- Halt/step: dbg_halt=1 -> halted=1 next cycle, pc_write=0. Pulse dbg_step -> exactly one cycle of pc_write=1, then HALTED. dbg_halt=0 -> RUN.
- Step hitting load-use: in HALTED, a load-use condition present, pulse dbg_step -> STEP holds through the stall cycle, then one advance cycle, then HALTED.
- Saturation: with CNT_W=4, force 20 load-use cycles -> stall_cnt = 15 and stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, taken-branch flush, debug halt/step FSM
// and saturating stall/flush event counters for the 5-stage core.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memread_idex,
  input  logic [REG_ADDR_W-1:0] rd_idex,
  input  logic [REG_ADDR_W-1:0] rs1_ifid,
  input  logic [REG_ADDR_W-1:0] rs2_ifid,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  branch_taken_exmem,
  input  logic                  dbg_halt,
  input  logic                  dbg_step,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ctrl_bubble,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic                  halted,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   load_use;
  logic   ld_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign load_use = memread_idex && (rd_idex != '0) &&
                    ((rs1_used && (rd_idex == rs1_ifid)) ||
                     (rs2_used && (rd_idex == rs2_ifid)));

  // A taken branch squashes the dependent instruction, and HALTED gating
  // already freezes IF, so only these cycles are true load-use stalls.
  assign ld_stall = load_use && !branch_taken_exmem && (state_q != HALTED);

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ctrl_bubble = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;

    unique case (state_q)
      RUN:     if (dbg_halt) state_d = HALTED;
      HALTED:  if (!dbg_halt) state_d = RUN;
               else if (dbg_step) state_d = STEP;
      STEP:    if (!ld_stall) state_d = HALTED;
      default: state_d = RUN;
    endcase

    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (branch_taken_exmem) begin
      // Redirect must be captured even while halted, so PC stays enabled.
      ctrl_bubble = 1'b1;
      flush_ifid  = 1'b1;
      flush_idex  = 1'b1;
      flush_exmem = 1'b1;
    end else if (ld_stall || (state_q == HALTED)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ctrl_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (ld_stall)           stall_cnt <= sat_inc(stall_cnt);
      if (branch_taken_exmem) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected
// responses; a negedge monitor pops and compares every presented cycle.
module tb_pipeline_hazard_ctrl;

  localparam int RW = 5;
  localparam int CW = 4;

  // {pc_write, ifid_write, ctrl_bubble, flush_ifid, flush_idex, flush_exmem}
  localparam logic [5:0] HZ_RUN   = 6'b110000;
  localparam logic [5:0] HZ_STALL = 6'b001000;
  localparam logic [5:0] HZ_FLUSH = 6'b111111;
  localparam logic [5:0] HZ_RST   = 6'b001111;

  logic          clk = 1'b0;
  logic          reset;
  logic          memread_idex;
  logic [RW-1:0] rd_idex, rs1_ifid, rs2_ifid;
  logic          rs1_used, rs2_used, branch_taken_exmem, dbg_halt, dbg_step;
  logic          pc_write, ifid_write, ctrl_bubble;
  logic          flush_ifid, flush_idex, flush_exmem, halted;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string         nm;
    logic [5:0]    hz;
    logic          hl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .memread_idex(memread_idex), .rd_idex(rd_idex),
    .rs1_ifid(rs1_ifid), .rs2_ifid(rs2_ifid),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .branch_taken_exmem(branch_taken_exmem),
    .dbg_halt(dbg_halt), .dbg_step(dbg_step),
    .pc_write(pc_write), .ifid_write(ifid_write), .ctrl_bubble(ctrl_bubble),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // One cycle: inputs applied just after posedge, expectation queued for the
  // monitor, which samples at the following negedge.
  task automatic cyc(input string nm, input logic rn, input logic mr,
                     input logic [RW-1:0] rd, input logic [RW-1:0] r1,
                     input logic [RW-1:0] r2, input logic u1, input logic u2,
                     input logic br, input logic h, input logic s,
                     input logic [5:0] ehz, input logic ehl,
                     input logic [CW-1:0] esc, input logic [CW-1:0] efc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rn; memread_idex = mr; rd_idex = rd; rs1_ifid = r1; rs2_ifid = r2;
    rs1_used = u1; rs2_used = u2; branch_taken_exmem = br;
    dbg_halt = h; dbg_step = s;
    e.nm = nm; e.hz = ehz; e.hl = ehl; e.sc = esc; e.fc = efc;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [5:0] hz;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        hz = {pc_write, ifid_write, ctrl_bubble, flush_ifid, flush_idex, flush_exmem};
        n_tests++;
        if (hz !== e.hz) begin
          n_fail++;
          $display("FAIL %s hazard: got %b want %b", e.nm, hz, e.hz);
        end
        n_tests++;
        if (halted !== e.hl) begin
          n_fail++;
          $display("FAIL %s halted: got %b want %b", e.nm, halted, e.hl);
        end
        n_tests++;
        if (stall_cnt !== e.sc) begin
          n_fail++;
          $display("FAIL %s stall_cnt: got %0d want %0d", e.nm, stall_cnt, e.sc);
        end
        n_tests++;
        if (flush_cnt !== e.fc) begin
          n_fail++;
          $display("FAIL %s flush_cnt: got %0d want %0d", e.nm, flush_cnt, e.fc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b0; memread_idex = 1'b0; rd_idex = '0; rs1_ifid = '0; rs2_ifid = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; branch_taken_exmem = 1'b1;
    dbg_halt = 1'b0; dbg_step = 1'b0;

    //   name        rn mr rd r1 r2 u1 u2 br h  s   hazard    hl sc  fc
    cyc("rst0",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ_RST,   0, 0,  0);
    cyc("rst1",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ_RST,   0, 0,  0);
    cyc("release",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, HZ_RUN,   0, 0,  0);
    cyc("lu_rs1",    1, 1, 5, 5, 0, 1, 0, 0, 0, 0, HZ_STALL, 0, 0,  0);
    cyc("lu_x0",     1, 1, 0, 0, 0, 1, 0, 0, 0, 0, HZ_RUN,   0, 1,  0);
    cyc("lu_rs2",    1, 1, 7, 3, 7, 1, 1, 0, 0, 0, HZ_STALL, 0, 1,  0);
    cyc("lu_unused", 1, 1, 7, 3, 7, 1, 0, 0, 0, 0, HZ_RUN,   0, 2,  0);
    cyc("br_and_lu", 1, 1, 5, 5, 0, 1, 0, 1, 0, 0, HZ_FLUSH, 0, 2,  0);
    cyc("idle",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, HZ_RUN,   0, 2,  1);
    cyc("halt_req",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_RUN,   0, 2,  1);
    cyc("halted",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_STALL, 1, 2,  1);
    cyc("step_req",  1, 0, 0, 0, 0, 0, 0, 0, 1, 1, HZ_STALL, 1, 2,  1);
    cyc("step_adv",  1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_RUN,   0, 2,  1);
    cyc("re_halted", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_STALL, 1, 2,  1);
    cyc("halt_br",   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, HZ_FLUSH, 1, 2,  1);
    cyc("halt_kept", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_STALL, 1, 2,  2);
    cyc("halt_lu",   1, 1, 5, 5, 0, 1, 0, 0, 1, 0, HZ_STALL, 1, 2,  2);
    cyc("step_lu",   1, 1, 5, 5, 0, 1, 0, 0, 1, 1, HZ_STALL, 1, 2,  2);
    cyc("step_stall",1, 1, 5, 5, 0, 1, 0, 0, 1, 0, HZ_STALL, 0, 2,  2);
    cyc("step_go",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_RUN,   0, 3,  2);
    cyc("step_done", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_STALL, 1, 3,  2);
    cyc("resume",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1, HZ_STALL, 1, 3,  2);
    cyc("running",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, HZ_RUN,   0, 3,  2);
    cyc("halt2_req", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_RUN,   0, 3,  2);
    cyc("halt2",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_STALL, 1, 3,  2);
    cyc("rst_halt",  0, 0, 0, 0, 0, 0, 0, 0, 1, 0, HZ_RST,   1, 3,  2);
    cyc("post_rst",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, HZ_RUN,   0, 0,  0);

    for (int i = 0; i < 20; i++)
      cyc("sat_stall", 1, 1, 9, 0, 9, 0, 1, 0, 0, 0, HZ_STALL, 0,
          (i > 15) ? 4'd15 : 4'(i), 0);
    cyc("sat_stall_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, HZ_RUN, 0, 15, 0);
    for (int i = 0; i < 20; i++)
      cyc("sat_flush", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, HZ_FLUSH, 0, 15,
          (i > 15) ? 4'd15 : 4'(i));
    cyc("sat_flush_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, HZ_RUN, 0, 15, 15);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
